// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : Chunked, carry-registered two's-complement adder/subtractor with
//             valid/ready flow control. One STAGE_BITS chunk is resolved per
//             stage; a single global advance moves or holds the whole pipe.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STAGES = WIDTH / STAGE_BITS;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             overflow_d;
    logic             overflow_q;

    // Subtraction is a + ~b + (cin ^ 1): cin acts as a borrow-in in sub mode.
    assign w_b_eff   = sub ? ~b : b;
    assign w_c0      = cin ^ sub;

    // The pipe moves as a unit; a bubble inside never releases a stall.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // Number of result bits resolved once this stage has registered.
            localparam int DONE_W = (k + 1) * STAGE_BITS;

            logic [STAGE_BITS-1:0] w_a;
            logic [STAGE_BITS-1:0] w_b;
            logic                  w_c;
            logic                  w_v;
            logic [STAGE_BITS:0]   w_add;
            logic [DONE_W-1:0]     sum_d;
            logic [DONE_W-1:0]     sum_q;
            logic                  carry_q;
            logic                  valid_q;

            if (k == 0) begin : g_src_port
                assign w_a = a[STAGE_BITS-1:0];
                assign w_b = w_b_eff[STAGE_BITS-1:0];
                assign w_c = w_c0;
                assign w_v = in_valid;
            end else begin : g_src_prev
                assign w_a = g_stage[k-1].g_fwd.opa_q[STAGE_BITS-1:0];
                assign w_b = g_stage[k-1].g_fwd.opb_q[STAGE_BITS-1:0];
                assign w_c = g_stage[k-1].carry_q;
                assign w_v = g_stage[k-1].valid_q;
            end

            // Only STAGE_BITS+1 bits of carry logic sit between registers.
            assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{STAGE_BITS{1'b0}}, w_c};

            if (k == 0) begin : g_sum_first
                assign sum_d = w_add[STAGE_BITS-1:0];
            end else begin : g_sum_next
                assign sum_d = {w_add[STAGE_BITS-1:0], g_stage[k-1].sum_q};
            end

            // Stage result: low chunks computed so far, chunk carry and valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                end else if (w_advance) begin
                    sum_q   <= sum_d;
                    carry_q <= w_add[STAGE_BITS];
                    valid_q <= w_v;
                end
            end

            // Unconsumed high chunks travel alongside until their stage.
            if (k < STAGES - 1) begin : g_fwd
                localparam int REM_W = WIDTH - (k + 1) * STAGE_BITS;

                logic [REM_W-1:0] opa_d;
                logic [REM_W-1:0] opb_d;
                logic [REM_W-1:0] opa_q;
                logic [REM_W-1:0] opb_q;

                if (k == 0) begin : g_fwd_port
                    assign opa_d = a[WIDTH-1:STAGE_BITS];
                    assign opb_d = w_b_eff[WIDTH-1:STAGE_BITS];
                end else begin : g_fwd_prev
                    assign opa_d = g_stage[k-1].g_fwd.opa_q[REM_W+STAGE_BITS-1:STAGE_BITS];
                    assign opb_d = g_stage[k-1].g_fwd.opb_q[REM_W+STAGE_BITS-1:STAGE_BITS];
                end

                // Delay the remaining operand chunks by one stage.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        opa_q <= '0;
                        opb_q <= '0;
                    end else if (w_advance) begin
                        opa_q <= opa_d;
                        opb_q <= opb_d;
                    end
                end
            end
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
    assign overflow_d = g_stage[STAGES-1].w_a[STAGE_BITS-1]
                      ^ g_stage[STAGES-1].w_b[STAGE_BITS-1]
                      ^ g_stage[STAGES-1].w_add[STAGE_BITS-1]
                      ^ g_stage[STAGES-1].w_add[STAGE_BITS];

    // Signed overflow flag registered alongside the final stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (w_advance) begin
            overflow_q <= overflow_d;
        end
    end

    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign out_valid = g_stage[STAGES-1].valid_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Purpose  : Self-checking bench for pipelined_adder in three shapes:
//             16/4 (latency 4), 8/8 (latency 1) and 32/1 (latency 32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic        cin_v       [3];
    logic        sub_v       [3];
    logic [31:0] a_v         [3];
    logic [31:0] b_v         [3];

    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        cout_v      [3];
    logic        ovf_v       [3];
    logic [31:0] sum_v       [3];

    wire        in_ready0, in_ready1, in_ready2;
    wire        out_valid0, out_valid1, out_valid2;
    wire        cout0, cout1, cout2;
    wire        ovf0, ovf1, ovf2;
    wire [15:0] sum0;
    wire [7:0]  sum1;
    wire [31:0] sum2;

    int W [3] = '{16, 8, 32};
    int L [3] = '{4, 1, 32};

    int total = 0;
    int bad   = 0;

    pipelined_adder #(.WIDTH(16), .STAGE_BITS(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid0), .out_ready(out_ready_v[0]), .sum(sum0),
        .cout(cout0), .overflow(ovf0)
    );

    pipelined_adder #(.WIDTH(8), .STAGE_BITS(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid1), .out_ready(out_ready_v[1]), .sum(sum1),
        .cout(cout1), .overflow(ovf1)
    );

    pipelined_adder #(.WIDTH(32), .STAGE_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready2),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid2), .out_ready(out_ready_v[2]), .sum(sum2),
        .cout(cout2), .overflow(ovf2)
    );

    // Collect the three DUTs' outputs into indexable arrays.
    always_comb begin
        sum_v[0]       = {16'h0000, sum0};
        sum_v[1]       = {24'h000000, sum1};
        sum_v[2]       = sum2;
        in_ready_v[0]  = in_ready0;
        in_ready_v[1]  = in_ready1;
        in_ready_v[2]  = in_ready2;
        out_valid_v[0] = out_valid0;
        out_valid_v[1] = out_valid1;
        out_valid_v[2] = out_valid2;
        cout_v[0]      = cout0;
        cout_v[1]      = cout1;
        cout_v[2]      = cout2;
        ovf_v[0]       = ovf0;
        ovf_v[1]       = ovf1;
        ovf_v[2]       = ovf2;
    end

    // Reference: integer arithmetic on unsigned and signed views of operands.
    // Returns {overflow, cout, sum[31:0]}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
        longint modv, half, ua, ub, sa, sb, ur, sr, m;
        logic   co, ov;
        modv = longint'(1) << w;
        half = modv / 2;
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        ua   = ua % modv;
        ub   = ub % modv;
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        if (!sub) begin
            ur = ua + ub + (cin ? 1 : 0);
            sr = sa + sb + (cin ? 1 : 0);
            co = (ur >= modv);
        end else begin
            ur = ua - ub - (cin ? 1 : 0);
            sr = sa - sb - (cin ? 1 : 0);
            co = (ur >= 0);
        end
        ov = (sr < -half) || (sr >= half);
        m  = ur & (modv - 1);
        return {ov, co, m[31:0]};
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic test_reset(input int d);
        @(negedge clk);
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (out_valid_v[d] !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid_v[d]);
        end
        total++;
        if (sum_v[d] !== 32'h0) begin
            bad++; $display("FAIL reset_sum dut%0d: got %h want 0", d, sum_v[d]);
        end
        total++;
        if (cout_v[d] !== 1'b0) begin
            bad++; $display("FAIL reset_cout dut%0d: got %b want 0", d, cout_v[d]);
        end
        total++;
        if (ovf_v[d] !== 1'b0) begin
            bad++; $display("FAIL reset_overflow dut%0d: got %b want 0", d, ovf_v[d]);
        end
        total++;
        if (in_ready_v[d] !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready_v[d]);
        end
    endtask

    // Single operations on an idle pipe: exact latency plus result fields.
    // Latency is counted in edges from the start of the handshake cycle.
    task automatic test_directed(input int d);
        int          w;
        int          lat;
        logic [31:0] mask, msb;
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic        vc [7];
        logic        vs [7];
        logic [33:0] e;
        logic [33:0] got;
        int          cnt;
        w    = W[d];
        lat  = L[d];
        mask = mask_of(w);
        msb  = 32'd1 << (w - 1);
        va[0] = 32'd1;       vb[0] = 32'd1; vc[0] = 1'b1; vs[0] = 1'b0;
        va[1] = mask;        vb[1] = 32'd1; vc[1] = 1'b0; vs[1] = 1'b0;
        va[2] = msb - 32'd1; vb[2] = 32'd1; vc[2] = 1'b0; vs[2] = 1'b0;
        va[3] = 32'd5;       vb[3] = 32'd3; vc[3] = 1'b0; vs[3] = 1'b1;
        va[4] = 32'd3;       vb[4] = 32'd5; vc[4] = 1'b0; vs[4] = 1'b1;
        va[5] = msb;         vb[5] = 32'd1; vc[5] = 1'b0; vs[5] = 1'b1;
        va[6] = 32'd5;       vb[6] = 32'd3; vc[6] = 1'b1; vs[6] = 1'b1;
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            a_v[d]         = va[v];
            b_v[d]         = vb[v];
            cin_v[d]       = vc[v];
            sub_v[d]       = vs[v];
            in_valid_v[d]  = 1'b1;
            out_ready_v[d] = 1'b1;
            e   = model(w, va[v], vb[v], vc[v], vs[v]);
            cnt = 0;
            got = '0;
            for (int i = 1; i <= lat + 4; i++) begin
                @(posedge clk);
                #1;
                if (i == 1) in_valid_v[d] = 1'b0;
                if (out_valid_v[d] === 1'b1 && cnt == 0) begin
                    cnt = i;
                    got = {ovf_v[d], cout_v[d], sum_v[d]};
                end
            end
            total++;
            if (cnt != lat) begin
                bad++; $display("FAIL dir_latency dut%0d vec%0d: got %0d want %0d", d, v, cnt, lat);
            end
            total++;
            if (got[31:0] !== e[31:0]) begin
                bad++; $display("FAIL dir_sum dut%0d vec%0d: got %h want %h", d, v, got[31:0], e[31:0]);
            end
            total++;
            if (got[32] !== e[32]) begin
                bad++; $display("FAIL dir_cout dut%0d vec%0d: got %b want %b", d, v, got[32], e[32]);
            end
            total++;
            if (got[33] !== e[33]) begin
                bad++; $display("FAIL dir_overflow dut%0d vec%0d: got %b want %b", d, v, got[33], e[33]);
            end
        end
    endtask

    // 16 back-to-back random operations with random output back-pressure.
    task automatic test_back_to_back(input int d);
        int          w;
        int          lat;
        logic [31:0] mask;
        logic [33:0] exp_q [$];
        logic [33:0] e;
        int          issued;
        int          received;
        int          cyc;
        logic        stalled;
        logic [33:0] held;
        w        = W[d];
        lat      = L[d];
        mask     = mask_of(w);
        issued   = 0;
        received = 0;
        cyc      = 0;
        stalled  = 1'b0;
        held     = '0;
        while (received < 16 && cyc < 16 * 6 + 3 * lat + 50) begin
            @(negedge clk);
            cyc++;
            in_valid_v[d]  = (issued < 16);
            a_v[d]         = $urandom() & mask;
            b_v[d]         = $urandom() & mask;
            cin_v[d]       = 1'($urandom_range(0, 1));
            sub_v[d]       = 1'($urandom_range(0, 1));
            out_ready_v[d] = ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (in_ready_v[d] !== !(out_valid_v[d] && !out_ready_v[d])) begin
                bad++; $display("FAIL b2b_in_ready dut%0d cyc%0d: got %b want %b", d, cyc,
                                in_ready_v[d], !(out_valid_v[d] && !out_ready_v[d]));
            end
            if (stalled) begin
                total++;
                if ({out_valid_v[d], ovf_v[d], cout_v[d], sum_v[d]} !== {1'b1, held}) begin
                    bad++; $display("FAIL b2b_hold dut%0d cyc%0d: got %b_%h want 1_%h", d, cyc,
                                    out_valid_v[d], {ovf_v[d], cout_v[d], sum_v[d]}, held);
                end
            end
            stalled = out_valid_v[d] && !out_ready_v[d];
            held    = {ovf_v[d], cout_v[d], sum_v[d]};
            if (out_valid_v[d] && out_ready_v[d]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra dut%0d cyc%0d: got result %h want none", d, cyc, held);
                end else begin
                    e = exp_q.pop_front();
                    if (held !== e) begin
                        bad++; $display("FAIL b2b_result dut%0d #%0d: got %h want %h", d, received, held, e);
                    end
                end
                received++;
            end
            if (in_valid_v[d] && in_ready_v[d]) begin
                exp_q.push_back(model(w, a_v[d], b_v[d], cin_v[d], sub_v[d]));
                issued++;
            end
        end
        total++;
        if (received != 16 || exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_count dut%0d: got received=%0d pending=%0d want 16 and 0",
                            d, received, exp_q.size());
        end
        @(negedge clk);
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        for (int i = 0; i < lat + 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid_v[d] !== 1'b0) begin
                bad++; $display("FAIL b2b_drain dut%0d: got out_valid %b want 0", d, out_valid_v[d]);
            end
        end
    endtask

    // Three operations issued, then reset: nothing may emerge afterwards.
    task automatic test_reset_midflight(input int d);
        int          w;
        int          lat;
        logic [31:0] mask;
        logic [33:0] e;
        logic [33:0] got;
        int          cnt;
        w    = W[d];
        lat  = L[d];
        mask = mask_of(w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_v[d]  = 1'b1;
            out_ready_v[d] = 1'b1;
            a_v[d]         = $urandom() & mask;
            b_v[d]         = $urandom() & mask;
            cin_v[d]       = 1'b0;
            sub_v[d]       = 1'b0;
        end
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < lat + 3; i++) begin
            #1;
            total++;
            if (out_valid_v[d] !== 1'b0) begin
                bad++; $display("FAIL mid_reset_out_valid dut%0d cyc%0d: got %b want 0", d, i, out_valid_v[d]);
            end
            @(negedge clk);
        end
        a_v[d]         = mask;
        b_v[d]         = 32'd2 & mask;
        cin_v[d]       = 1'b1;
        sub_v[d]       = 1'b1;
        in_valid_v[d]  = 1'b1;
        e   = model(w, mask, 32'd2 & mask, 1'b1, 1'b1);
        cnt = 0;
        got = '0;
        for (int i = 1; i <= lat + 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) in_valid_v[d] = 1'b0;
            if (out_valid_v[d] === 1'b1 && cnt == 0) begin
                cnt = i;
                got = {ovf_v[d], cout_v[d], sum_v[d]};
            end
        end
        total++;
        if (cnt != lat || got !== e) begin
            bad++; $display("FAIL mid_reset_next dut%0d: got lat=%0d res=%h want lat=%0d res=%h",
                            d, cnt, got, lat, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b0;
            cin_v[d]       = 1'b0;
            sub_v[d]       = 1'b0;
            a_v[d]         = 32'h0;
            b_v[d]         = 32'h0;
        end
        for (int d = 0; d < 3; d++) begin
            test_reset(d);
            test_directed(d);
            test_back_to_back(d);
            test_reset_midflight(d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
